fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage WISC-SP20 pipeline.
- Owns the PC and drives a stall-capable instruction memory.
- Consumes stall_decode and flush_fetch from the hazard unit.
- Presents the fetched instruction and PC+2 to decode.
- Absorbs multi-cycle memory latency, decode back-pressure, branch redirects and HALT.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus for the fetch stage
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_data,
    input  imem_done
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_data,
    output imem_done
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - WISC-SP20 instruction fetch stage with IF/ID register
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INS  = 16'h0800,
  parameter logic [4:0]  HALT_OP  = 5'b00000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_decode_i,
  input  logic                flush_fetch_i,
  input  logic [15:0]         branch_target_i,
  fetch_stage_if.master       imem,
  output logic [15:0]         pc_o,
  output logic [15:0]         if_id_ins_o,
  output logic [15:0]         if_id_pc_plus2_o,
  output logic                if_id_valid_o,
  output logic                fetch_busy_o
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_HALTED,
    ST_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_q, ins_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic        valid_q, valid_d;
  logic [15:0] buf_ins_q, buf_ins_d;
  logic [15:0] buf_pcp2_q, buf_pcp2_d;
  logic        buf_valid_q, buf_valid_d;

  logic [15:0] pc_plus2;
  logic        capture;
  logic        cap_is_halt;
  logic        buf_is_halt;

  assign pc_plus2    = pc_q + 16'd2;
  assign capture     = imem.imem_done && ((state_q == ST_FETCH) || (state_q == ST_WAIT));
  assign cap_is_halt = (imem.imem_data[15:11] == HALT_OP);
  assign buf_is_halt = (buf_ins_q[15:11] == HALT_OP);

  assign imem.imem_addr = pc_q;
  assign imem.imem_rd   = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign fetch_busy_o   = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

  assign pc_o             = pc_q;
  assign if_id_ins_o      = ins_q;
  assign if_id_pc_plus2_o = pcp2_q;
  assign if_id_valid_o    = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    pcp2_d      = pcp2_q;
    valid_d     = valid_q;
    buf_ins_d   = buf_ins_q;
    buf_pcp2_d  = buf_pcp2_q;
    buf_valid_d = buf_valid_q;

    if (flush_fetch_i) begin
      // Redirect wins; an unfinished read in WAIT must still be drained.
      pc_d        = branch_target_i;
      ins_d       = NOP_INS;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
      if ((state_q == ST_WAIT && !imem.imem_done) || state_q == ST_DRAIN)
        state_d = ST_DRAIN;
      else
        state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH, ST_WAIT: begin
          if (capture) begin
            pc_d = cap_is_halt ? pc_q : pc_plus2;
            if (!stall_decode_i) begin
              ins_d   = imem.imem_data;
              pcp2_d  = pc_plus2;
              valid_d = 1'b1;
              state_d = cap_is_halt ? ST_HALTED : ST_FETCH;
            end else begin
              buf_ins_d   = imem.imem_data;
              buf_pcp2_d  = pc_plus2;
              buf_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end else begin
            state_d = ST_WAIT;
            if (!stall_decode_i) begin
              ins_d   = NOP_INS;
              valid_d = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_decode_i) begin
            ins_d       = buf_ins_q;
            pcp2_d      = buf_pcp2_q;
            valid_d     = 1'b1;
            buf_valid_d = 1'b0;
            state_d     = buf_is_halt ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (!stall_decode_i) begin
            ins_d   = NOP_INS;
            valid_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (imem.imem_done)
            state_d = ST_FETCH;
          if (!stall_decode_i) begin
            ins_d   = NOP_INS;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ins_q       <= NOP_INS;
      pcp2_q      <= 16'h0000;
      valid_q     <= 1'b0;
      buf_ins_q   <= NOP_INS;
      buf_pcp2_q  <= 16'h0000;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      pcp2_q      <= pcp2_d;
      valid_q     <= valid_d;
      buf_ins_q   <= buf_ins_d;
      buf_pcp2_q  <= buf_pcp2_d;
      buf_valid_q <= buf_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_decode = 1'b0;
  logic        flush_fetch = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] pc, if_id_ins, if_id_pc_plus2;
  logic        if_id_valid, fetch_busy;
  int          tests = 0;
  int          fails = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_decode_i   (stall_decode),
    .flush_fetch_i    (flush_fetch),
    .branch_target_i  (branch_target),
    .imem             (imem.master),
    .pc_o             (pc),
    .if_id_ins_o      (if_id_ins),
    .if_id_pc_plus2_o (if_id_pc_plus2),
    .if_id_valid_o    (if_id_valid),
    .fetch_busy_o     (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem.imem_done = 1'b0; imem.imem_data = 16'h0000;
    step(); step();
    rst = 1'b0;
    tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h exp 0000", pc); end
    tests++; if (if_id_ins !== 16'h0800) begin fails++; $display("FAIL reset_ins got %h exp 0800", if_id_ins); end
    tests++; if (if_id_pc_plus2 !== 16'h0000) begin fails++; $display("FAIL reset_pcp2 got %h exp 0000", if_id_pc_plus2); end
    tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    tests++; if (imem.imem_rd !== 1'b1 || fetch_busy !== 1'b0) begin fails++; $display("FAIL reset_rd_busy got %b%b exp 10", imem.imem_rd, fetch_busy); end
  endtask

  task automatic test_single_cycle();
    imem.imem_done = 1'b1; imem.imem_data = 16'hC001;
    step();
    tests++; if (if_id_ins !== 16'hC001 || if_id_pc_plus2 !== 16'h0002 || if_id_valid !== 1'b1) begin fails++; $display("FAIL sc_first got %h/%h/%b exp c001/0002/1", if_id_ins, if_id_pc_plus2, if_id_valid); end
    imem.imem_data = 16'hC102;
    step();
    tests++; if (if_id_ins !== 16'hC102 || if_id_pc_plus2 !== 16'h0004 || if_id_valid !== 1'b1) begin fails++; $display("FAIL sc_second got %h/%h/%b exp c102/0004/1", if_id_ins, if_id_pc_plus2, if_id_valid); end
    tests++; if (pc !== 16'h0004 || imem.imem_addr !== 16'h0004) begin fails++; $display("FAIL sc_pc got %h/%h exp 0004", pc, imem.imem_addr); end
    imem.imem_done = 1'b0;
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (fetch_busy !== 1'b1 || imem.imem_addr !== 16'h0004 || imem.imem_rd !== 1'b1) begin fails++; $display("FAIL wait_busy cyc %0d got %b/%h/%b exp 1/0004/1", i, fetch_busy, imem.imem_addr, imem.imem_rd); end
      tests++; if (if_id_ins !== 16'h0800 || if_id_valid !== 1'b0) begin fails++; $display("FAIL wait_bubble cyc %0d got %h/%b exp 0800/0", i, if_id_ins, if_id_valid); end
    end
    imem.imem_done = 1'b1; imem.imem_data = 16'hC203;
    step();
    imem.imem_done = 1'b0;
    tests++; if (if_id_ins !== 16'hC203 || if_id_pc_plus2 !== 16'h0006 || if_id_valid !== 1'b1) begin fails++; $display("FAIL wait_capture got %h/%h/%b exp c203/0006/1", if_id_ins, if_id_pc_plus2, if_id_valid); end
    tests++; if (pc !== 16'h0006 || fetch_busy !== 1'b0) begin fails++; $display("FAIL wait_pc got %h/%b exp 0006/0", pc, fetch_busy); end
  endtask

  task automatic test_halt();
    imem.imem_done = 1'b1; imem.imem_data = 16'h0000;
    step();
    imem.imem_done = 1'b0;
    tests++; if (if_id_ins !== 16'h0000 || if_id_pc_plus2 !== 16'h0008 || if_id_valid !== 1'b1) begin fails++; $display("FAIL halt_ins got %h/%h/%b exp 0000/0008/1", if_id_ins, if_id_pc_plus2, if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (pc !== 16'h0006 || imem.imem_rd !== 1'b0) begin fails++; $display("FAIL halt_idle cyc %0d got %h/%b exp 0006/0", i, pc, imem.imem_rd); end
      step();
    end
    tests++; if (if_id_ins !== 16'h0800 || if_id_valid !== 1'b0) begin fails++; $display("FAIL halt_bubble got %h/%b exp 0800/0", if_id_ins, if_id_valid); end
    flush_fetch = 1'b1; branch_target = 16'h0010;
    step();
    flush_fetch = 1'b0;
    tests++; if (pc !== 16'h0010 || imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'h0010) begin fails++; $display("FAIL halt_resume got %h/%b/%h exp 0010/1/0010", pc, imem.imem_rd, imem.imem_addr); end
    imem.imem_done = 1'b1; imem.imem_data = 16'h1111;
    step();
    tests++; if (if_id_ins !== 16'h1111 || if_id_pc_plus2 !== 16'h0012 || pc !== 16'h0012) begin fails++; $display("FAIL halt_refetch got %h/%h/%h exp 1111/0012/0012", if_id_ins, if_id_pc_plus2, pc); end
  endtask

  task automatic test_stall();
    imem.imem_done = 1'b1; imem.imem_data = 16'h4123; stall_decode = 1'b1;
    step();
    imem.imem_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++; if (if_id_ins !== 16'h1111 || if_id_pc_plus2 !== 16'h0012 || if_id_valid !== 1'b1) begin fails++; $display("FAIL stall_hold cyc %0d got %h/%h/%b exp 1111/0012/1", i, if_id_ins, if_id_pc_plus2, if_id_valid); end
      tests++; if (imem.imem_rd !== 1'b0 || pc !== 16'h0014) begin fails++; $display("FAIL stall_rd cyc %0d got %b/%h exp 0/0014", i, imem.imem_rd, pc); end
      if (i == 0) step();
    end
    stall_decode = 1'b0;
    step();
    tests++; if (if_id_ins !== 16'h4123 || if_id_pc_plus2 !== 16'h0014 || if_id_valid !== 1'b1) begin fails++; $display("FAIL stall_release got %h/%h/%b exp 4123/0014/1", if_id_ins, if_id_pc_plus2, if_id_valid); end
    tests++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'h0014) begin fails++; $display("FAIL stall_resume got %b/%h exp 1/0014", imem.imem_rd, imem.imem_addr); end
  endtask

  task automatic test_flush_drain();
    step();
    tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL flush_prewait got %b exp 1", fetch_busy); end
    flush_fetch = 1'b1; branch_target = 16'h0040;
    step();
    flush_fetch = 1'b0;
    tests++; if (pc !== 16'h0040 || fetch_busy !== 1'b1 || if_id_valid !== 1'b0 || if_id_ins !== 16'h0800) begin fails++; $display("FAIL flush_drain got %h/%b/%b/%h exp 0040/1/0/0800", pc, fetch_busy, if_id_valid, if_id_ins); end
    step();
    tests++; if (fetch_busy !== 1'b1 || if_id_valid !== 1'b0) begin fails++; $display("FAIL flush_drain2 got %b/%b exp 1/0", fetch_busy, if_id_valid); end
    imem.imem_done = 1'b1; imem.imem_data = 16'hDEAD;
    step();
    tests++; if (if_id_valid !== 1'b0 || if_id_ins !== 16'h0800 || fetch_busy !== 1'b0 || imem.imem_addr !== 16'h0040) begin fails++; $display("FAIL flush_discard got %b/%h/%b/%h exp 0/0800/0/0040", if_id_valid, if_id_ins, fetch_busy, imem.imem_addr); end
    imem.imem_data = 16'hC440;
    step();
    imem.imem_done = 1'b0;
    tests++; if (if_id_ins !== 16'hC440 || if_id_pc_plus2 !== 16'h0042 || if_id_valid !== 1'b1) begin fails++; $display("FAIL flush_target got %h/%h/%b exp c440/0042/1", if_id_ins, if_id_pc_plus2, if_id_valid); end
  endtask

  task automatic test_wrap_and_reset();
    flush_fetch = 1'b1; branch_target = 16'hFFFE;
    step();
    flush_fetch = 1'b0;
    tests++; if (pc !== 16'hFFFE || if_id_pc_plus2 !== 16'h0042) begin fails++; $display("FAIL wrap_setup got %h/%h exp fffe/0042", pc, if_id_pc_plus2); end
    imem.imem_done = 1'b1; imem.imem_data = 16'hC0FF;
    step();
    tests++; if (pc !== 16'h0000 || if_id_pc_plus2 !== 16'h0000 || if_id_ins !== 16'hC0FF) begin fails++; $display("FAIL wrap got %h/%h/%h exp 0000/0000/c0ff", pc, if_id_pc_plus2, if_id_ins); end
    imem.imem_data = 16'hC1FF;
    step();
    imem.imem_done = 1'b0;
    step();
    tests++; if (pc !== 16'h0002 || fetch_busy !== 1'b1) begin fails++; $display("FAIL prereset_wait got %h/%b exp 0002/1", pc, fetch_busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (pc !== 16'h0000 || fetch_busy !== 1'b0 || if_id_valid !== 1'b0 || if_id_ins !== 16'h0800 || if_id_pc_plus2 !== 16'h0000) begin fails++; $display("FAIL midwait_reset got %h/%b/%b/%h/%h exp 0000/0/0/0800/0000", pc, fetch_busy, if_id_valid, if_id_ins, if_id_pc_plus2); end
  endtask

  initial begin
    imem.imem_done = 1'b0;
    imem.imem_data = 16'h0000;
    test_reset();
    test_single_cycle();
    test_wait();
    test_halt();
    test_stall();
    test_flush_drain();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
